instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Issues sequential word fetches to instruction memory, tracks in-flight
// requests, buffers returned instructions in a small FIFO and presents the
// FIFO head to the IF pipeline register. A redirect flushes the buffer and
// drops responses to requests that were issued before it.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcWrite,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_instr
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [31:0]   req_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   buf_pc    [DEPTH];
   logic [31:0]   buf_instr [DEPTH];

   logic          req_fire;
   logic          pop_en;
   logic          push_en;
   logic          drop_resp;
   logic          fifo_empty;
   logic          fifo_full;
   logic [31:0]   target_pc;
   logic [CW:0]   credits_used;
   logic [CW-1:0] outstanding_after_resp;
   logic [PW-1:0] wr_ptr_next;
   logic [PW-1:0] rd_ptr_next;

   assign target_pc   = {redirect_pc[31:2], 2'b00};
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == DEPTH_CNT);
   assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
   assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

   assign fetch_valid = !reset && !fifo_empty;
   assign fetch_pc    = buf_pc[rd_ptr];
   assign fetch_instr = buf_instr[rd_ptr];

   // Redirect wins over both the pop and the push of the same cycle.
   assign pop_en    = pcWrite && fetch_valid && !redirect_valid;
   assign drop_resp = (discard != '0);
   assign push_en   = imem_resp_valid && !drop_resp && !redirect_valid && !reset;

   assign outstanding_after_resp = outstanding - CW'(imem_resp_valid);

   // Every in-flight request and every buffered entry holds one slot of
   // DEPTH. A slot freed by this cycle's pop can be reused immediately,
   // which is what sustains one fetch per cycle with a two-entry buffer.
   // A response only moves a slot from in-flight to buffered, so it frees
   // nothing and the buffer can never be pushed while full.
   assign credits_used   = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop_en);
   assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = req_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Request PC advances per accepted request, response PC per kept response; both jump on redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_pc  <= RESET_PC;
         resp_pc <= RESET_PC;
      end else if (redirect_valid) begin
         req_pc  <= target_pc;
         resp_pc <= target_pc;
      end else begin
         if (req_fire) begin
            req_pc <= req_pc + 32'd4;
         end
         if (push_en) begin
            resp_pc <= resp_pc + 32'd4;
         end
      end
   end

   // In-flight count, plus the number of stale responses still to be thrown away after a redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect_valid) begin
         outstanding <= outstanding_after_resp;
         discard     <= outstanding_after_resp;
      end else begin
         outstanding <= outstanding_after_resp + CW'(req_fire);
         if (imem_resp_valid && drop_resp) begin
            discard <= discard - CW'(1);
         end
      end
   end

   // Instruction buffer: entries are cleared on reset so the presented bundle reads as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) begin
            buf_pc[wr_ptr]    <= resp_pc;
            buf_instr[wr_ptr] <= imem_resp_data;
            wr_ptr            <= wr_ptr_next;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr_next;
         end
         if (push_en && !pop_en) begin
            count <= count + CW'(1);
         end else if (!push_en && pop_en) begin
            count <= count - CW'(1);
         end
      end
   end

   // Slot accounting guarantees the buffer has room whenever a response is kept.
   assert property (@(posedge clk) disable iff (reset) !(push_en && fifo_full))
      else $error("instr_fetch_unit: response pushed into a full fetch buffer");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a simple in-order memory model.
// Scenarios run back to back on one continuous timeline; each task leaves
// the unit in a known state for the next one.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        pcWrite;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;

   logic        stall;
   logic [31:0] mem_q [$];
   logic [31:0] mem_addr;
   int          checks;
   int          fails;

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pcWrite         (pcWrite),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .fetch_valid     (fetch_valid),
      .fetch_pc        (fetch_pc),
      .fetch_instr     (fetch_instr)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_1357;
   endfunction

   // Memory model: accepted addresses are queued and returned in order one
   // cycle later unless stalled; reset empties it in the same cycle.
   always @(posedge clk) begin
      if (reset) begin
         mem_q.delete();
         imem_resp_valid <= 1'b0;
         imem_resp_data  <= '0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
         end
         if (!stall && mem_q.size() != 0) begin
            mem_addr = mem_q.pop_front();
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= instr_of(mem_addr);
         end else begin
            imem_resp_valid <= 1'b0;
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      pcWrite        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      stall          = 1'b0;
      tick();
      tick();
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); fails++; end checks++;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL reset_fetch_valid: got %b expected 0", fetch_valid); fails++; end checks++;
      reset   = 1'b0;
      pcWrite = 1'b1;
      #1;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL post_reset_valid: got %b expected 0", fetch_valid); fails++; end checks++;
      if (fetch_pc !== 32'h0) begin $display("[TB] FAIL post_reset_pc: got %h expected 0", fetch_pc); fails++; end checks++;
      if (fetch_instr !== 32'h0) begin $display("[TB] FAIL post_reset_instr: got %h expected 0", fetch_instr); fails++; end checks++;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL post_reset_req_valid: got %b expected 1", imem_req_valid); fails++; end checks++;
      if (imem_req_addr !== 32'h0) begin $display("[TB] FAIL post_reset_addr: got %h expected 0", imem_req_addr); fails++; end checks++;
   endtask

   task automatic test_stream();
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         if (fetch_valid !== 1'b1) begin $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", k, fetch_valid); fails++; end checks++;
         if (fetch_pc !== 32'(4*k)) begin $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", k, fetch_pc, 32'(4*k)); fails++; end checks++;
         if (fetch_instr !== instr_of(32'(4*k))) begin $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", k, fetch_instr, instr_of(32'(4*k))); fails++; end checks++;
         if (imem_req_addr !== 32'(4*k + 8)) begin $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", k, imem_req_addr, 32'(4*k + 8)); fails++; end checks++;
         tick();
      end
   endtask

   task automatic test_stall();
      pcWrite = 1'b0;
      #1;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL stall_full_req: got %b expected 0", imem_req_valid); fails++; end checks++;
      for (int k = 0; k < 5; k++) tick();
      if (fetch_valid !== 1'b1) begin $display("[TB] FAIL stall_valid: got %b expected 1", fetch_valid); fails++; end checks++;
      if (fetch_pc !== 32'h18) begin $display("[TB] FAIL stall_pc_held: got %h expected 00000018", fetch_pc); fails++; end checks++;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL stall_req_valid: got %b expected 0", imem_req_valid); fails++; end checks++;
      if (imem_req_addr !== 32'h20) begin $display("[TB] FAIL stall_addr: got %h expected 00000020", imem_req_addr); fails++; end checks++;
      pcWrite = 1'b1;
      #1;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL drain_req_valid: got %b expected 1", imem_req_valid); fails++; end checks++;
      for (int k = 0; k < 4; k++) begin
         if (fetch_pc !== 32'(32'h18 + 4*k)) begin $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", k, fetch_pc, 32'(32'h18 + 4*k)); fails++; end checks++;
         if (fetch_valid !== 1'b1) begin $display("[TB] FAIL drain_valid[%0d]: got %b expected 1", k, fetch_valid); fails++; end checks++;
         tick();
      end
   endtask

   task automatic test_ready_low();
      imem_req_ready = 1'b0;
      #1;
      if (imem_req_addr !== 32'h30) begin $display("[TB] FAIL ready_low_addr0: got %h expected 00000030", imem_req_addr); fails++; end checks++;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL ready_low_valid0: got %b expected 1", imem_req_valid); fails++; end checks++;
      tick();
      if (imem_req_addr !== 32'h30) begin $display("[TB] FAIL ready_low_addr1: got %h expected 00000030", imem_req_addr); fails++; end checks++;
      if (fetch_pc !== 32'h2C) begin $display("[TB] FAIL ready_low_pc1: got %h expected 0000002c", fetch_pc); fails++; end checks++;
      tick();
      if (imem_req_addr !== 32'h30) begin $display("[TB] FAIL ready_low_addr2: got %h expected 00000030", imem_req_addr); fails++; end checks++;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL ready_low_valid2: got %b expected 1", imem_req_valid); fails++; end checks++;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL ready_low_empty: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      imem_req_ready = 1'b1;
      #1;
      if (imem_req_addr !== 32'h30) begin $display("[TB] FAIL ready_resume_addr: got %h expected 00000030", imem_req_addr); fails++; end checks++;
      tick();
      tick();
      if (fetch_valid !== 1'b1) begin $display("[TB] FAIL ready_resume_valid: got %b expected 1", fetch_valid); fails++; end checks++;
      if (fetch_pc !== 32'h30) begin $display("[TB] FAIL ready_resume_pc0: got %h expected 00000030", fetch_pc); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h34) begin $display("[TB] FAIL ready_resume_pc1: got %h expected 00000034", fetch_pc); fails++; end checks++;
      if (imem_req_addr !== 32'h3C) begin $display("[TB] FAIL ready_resume_addr1: got %h expected 0000003c", imem_req_addr); fails++; end checks++;
   endtask

   task automatic test_redirect_discard();
      stall = 1'b1;
      tick();
      if (fetch_pc !== 32'h38) begin $display("[TB] FAIL disc_pre_pc: got %h expected 00000038", fetch_pc); fails++; end checks++;
      tick();
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL disc_two_inflight: got %b expected 0", imem_req_valid); fails++; end checks++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      stall          = 1'b0;
      #1;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL disc_redirect_req: got %b expected 0", imem_req_valid); fails++; end checks++;
      tick();
      redirect_valid = 1'b0;
      #1;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL disc_flush: got %b expected 0", fetch_valid); fails++; end checks++;
      if (imem_req_addr !== 32'h100) begin $display("[TB] FAIL disc_target: got %h expected 00000100", imem_req_addr); fails++; end checks++;
      tick();
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL disc_drop1: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL disc_drop2: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      if (fetch_valid !== 1'b1) begin $display("[TB] FAIL disc_first_valid: got %b expected 1", fetch_valid); fails++; end checks++;
      if (fetch_pc !== 32'h100) begin $display("[TB] FAIL disc_first_pc: got %h expected 00000100", fetch_pc); fails++; end checks++;
      if (fetch_instr !== instr_of(32'h100)) begin $display("[TB] FAIL disc_first_instr: got %h expected %h", fetch_instr, instr_of(32'h100)); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h104) begin $display("[TB] FAIL disc_second_pc: got %h expected 00000104", fetch_pc); fails++; end checks++;
   endtask

   task automatic test_redirect_collision();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL coll_req: got %b expected 0", imem_req_valid); fails++; end checks++;
      tick();
      redirect_valid = 1'b0;
      #1;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL coll_flush: got %b expected 0", fetch_valid); fails++; end checks++;
      if (imem_req_addr !== 32'h200) begin $display("[TB] FAIL coll_target: got %h expected 00000200", imem_req_addr); fails++; end checks++;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL coll_req_after: got %b expected 1", imem_req_valid); fails++; end checks++;
      tick();
      tick();
      if (fetch_pc !== 32'h200) begin $display("[TB] FAIL coll_first_pc: got %h expected 00000200", fetch_pc); fails++; end checks++;
      if (fetch_instr !== instr_of(32'h200)) begin $display("[TB] FAIL coll_first_instr: got %h expected %h", fetch_instr, instr_of(32'h200)); fails++; end checks++;
   endtask

   task automatic test_back_to_back();
      stall = 1'b1;
      tick();
      if (fetch_pc !== 32'h204) begin $display("[TB] FAIL b2b_pre_pc: got %h expected 00000204", fetch_pc); fails++; end checks++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_pc = 32'h404;
      stall       = 1'b0;
      #1;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL b2b_req: got %b expected 0", imem_req_valid); fails++; end checks++;
      if (imem_req_addr !== 32'h300) begin $display("[TB] FAIL b2b_first_target: got %h expected 00000300", imem_req_addr); fails++; end checks++;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL b2b_flush: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      redirect_valid = 1'b0;
      #1;
      if (imem_req_addr !== 32'h404) begin $display("[TB] FAIL b2b_last_target: got %h expected 00000404", imem_req_addr); fails++; end checks++;
      if (imem_req_valid !== 1'b1) begin $display("[TB] FAIL b2b_req_after: got %b expected 1", imem_req_valid); fails++; end checks++;
      tick();
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL b2b_stale_dropped: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h404) begin $display("[TB] FAIL b2b_first_pc: got %h expected 00000404", fetch_pc); fails++; end checks++;
      if (fetch_instr !== instr_of(32'h404)) begin $display("[TB] FAIL b2b_first_instr: got %h expected %h", fetch_instr, instr_of(32'h404)); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h408) begin $display("[TB] FAIL b2b_second_pc: got %h expected 00000408", fetch_pc); fails++; end checks++;
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      #1;
      if (imem_req_addr !== 32'hFFFF_FFFC) begin $display("[TB] FAIL wrap_start_addr: got %h expected fffffffc", imem_req_addr); fails++; end checks++;
      tick();
      if (imem_req_addr !== 32'h0) begin $display("[TB] FAIL wrap_next_addr: got %h expected 00000000", imem_req_addr); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'hFFFF_FFFC) begin $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", fetch_pc); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h0) begin $display("[TB] FAIL wrap_pc1: got %h expected 00000000", fetch_pc); fails++; end checks++;
      if (fetch_instr !== instr_of(32'h0)) begin $display("[TB] FAIL wrap_instr1: got %h expected %h", fetch_instr, instr_of(32'h0)); fails++; end checks++;
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      #1;
      if (imem_req_valid !== 1'b0) begin $display("[TB] FAIL mid_reset_req: got %b expected 0", imem_req_valid); fails++; end checks++;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL mid_reset_valid: got %b expected 0", fetch_valid); fails++; end checks++;
      tick();
      reset = 1'b0;
      #1;
      if (fetch_valid !== 1'b0) begin $display("[TB] FAIL mid_post_valid: got %b expected 0", fetch_valid); fails++; end checks++;
      if (fetch_pc !== 32'h0) begin $display("[TB] FAIL mid_post_pc: got %h expected 00000000", fetch_pc); fails++; end checks++;
      if (fetch_instr !== 32'h0) begin $display("[TB] FAIL mid_post_instr: got %h expected 00000000", fetch_instr); fails++; end checks++;
      if (imem_req_addr !== 32'h0) begin $display("[TB] FAIL mid_post_addr: got %h expected 00000000", imem_req_addr); fails++; end checks++;
      tick();
      tick();
      if (fetch_pc !== 32'h0) begin $display("[TB] FAIL mid_restart_pc0: got %h expected 00000000", fetch_pc); fails++; end checks++;
      if (fetch_instr !== instr_of(32'h0)) begin $display("[TB] FAIL mid_restart_instr0: got %h expected %h", fetch_instr, instr_of(32'h0)); fails++; end checks++;
      tick();
      if (fetch_pc !== 32'h4) begin $display("[TB] FAIL mid_restart_pc1: got %h expected 00000004", fetch_pc); fails++; end checks++;
   endtask

   // Scenario sequence and summary.
   initial begin
      checks = 0;
      fails  = 0;
      $display("[TB] instr_fetch_unit directed test start");
      test_reset();
      test_stream();
      test_stall();
      test_ready_low();
      test_redirect_discard();
      test_redirect_collision();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
